// File: rtl/chroni_vram_fetch.sv
// chroni_vram_fetch: burst fetch of up to 256 VRAM bytes over a four-phase
// rd_req/rd_ack handshake into a show-ahead FIFO read by the display pipeline.
// Optional macro FETCH_TIMEOUT_EN adds a per-phase watchdog that aborts a stuck burst.
module chroni_vram_fetch #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          CLK_200,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [7:0]                    page_in,
  input  logic [13:0]                   base_in,
  input  logic [8:0]                    len_in,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          rd_req,
  output logic [13:0]                   addr_out,
  output logic [7:0]                    addr_out_page,
  input  logic [7:0]                    data_in,
  input  logic                          rd_ack,
  input  logic                          pop,
  output logic [7:0]                    fifo_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE, WAIT_SPACE} state_t;

  state_t        state;
  logic [8:0]    len_r;
  logic [8:0]    cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop_ok;
  logic          flush;
  logic          tmo_hit;

  // A byte is captured on the first acknowledged cycle of a request phase.
  assign push       = (state == REQ) && rd_ack;
  // Pops against an empty FIFO are dropped.
  assign pop_ok     = pop && (fifo_level != '0);
  // Any accepted start (including len 0) discards stale FIFO contents.
  assign flush      = (state == IDLE) && start;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_data  = mem[rd_ptr];

  // Burst sequencer: request, wait for ack release, then check FIFO space.
  always_ff @(posedge CLK_200) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_req        <= 1'b0;
      addr_out      <= '0;
      addr_out_page <= '0;
      len_r         <= '0;
      cnt           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_out      <= base_in;
            addr_out_page <= page_in;
            len_r         <= len_in;
            cnt           <= '0;
            if (len_in == 9'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (fifo_level < FULL_LEVEL) begin
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= RELEASE;
          end else if (tmo_hit) begin
            rd_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        RELEASE: begin
          if (!rd_ack) begin
            cnt      <= cnt + 9'd1;
            // 14-bit wrap; the page register is never touched mid-burst.
            addr_out <= addr_out + 14'd1;
            if ((cnt + 9'd1) < len_r) begin
              state <= WAIT_SPACE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and level; flush wins over a coincident pop.
  always_ff @(posedge CLK_200) begin
    if (!reset_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage write; no reset needed since the level gates every read.
  always_ff @(posedge CLK_200) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tcnt;
  logic          err_q;

  // Fires on the last allowed cycle of a phase that is still waiting on the responder.
  assign tmo_hit = ((state == REQ && !rd_ack) || (state == RELEASE && rd_ack)) &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  // Per-phase watchdog: zero outside REQ/RELEASE and on every phase entry.
  always_ff @(posedge CLK_200) begin
    if (!reset_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (tmo_hit || state == IDLE || state == WAIT_SPACE || push ||
          (state == RELEASE && !rd_ack)) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_chroni_vram_fetch.sv
`timescale 1ns/1ps
module tb_chroni_vram_fetch;

  localparam int DEPTH = 16;
  localparam int TMO   = 255;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK_200 = 1'b0;
  logic          reset_n;
  logic          start;
  logic [7:0]    page_in;
  logic [13:0]   base_in;
  logic [8:0]    len_in;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_req;
  logic [13:0]   addr_out;
  logic [7:0]    addr_out_page;
  logic [7:0]    data_in;
  logic          rd_ack;
  logic          pop;
  logic [7:0]    fifo_data;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  logic [7:0] model_q[$];
  int checks = 0;
  int errors = 0;

  always #2.5 CLK_200 = ~CLK_200;

  chroni_vram_fetch #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_200(CLK_200), .reset_n(reset_n), .start(start), .page_in(page_in),
    .base_in(base_in), .len_in(len_in), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .addr_out(addr_out), .addr_out_page(addr_out_page),
    .data_in(data_in), .rd_ack(rd_ack), .pop(pop), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic pulse_start(input logic [7:0] pg, input logic [13:0] b,
                             input logic [8:0] l, input bit with_pop);
    start = 1'b1; page_in = pg; base_in = b; len_in = l; pop = with_pop;
    @(negedge CLK_200);
    start = 1'b0; pop = 1'b0;
  endtask

  // Acts as the VRAM responder for one byte and updates the FIFO model.
  task automatic serve_one(input int delay, input logic [13:0] exp_addr,
                           input logic [7:0] exp_page, input bit pop_with_ack,
                           input string tag);
    int t;
    logic [7:0] d;
    logic [7:0] head;
    t = 0;
    while (rd_req !== 1'b1 && t < 100) begin
      @(negedge CLK_200);
      t++;
    end
    checks++;
    if (rd_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: rd_req=%b after %0d cycles, required 1", tag, rd_req, t);
    end else begin
      repeat (delay) @(negedge CLK_200);
      checks++;
      if (addr_out !== exp_addr || addr_out_page !== exp_page || rd_req !== 1'b1) begin
        errors++;
        $display("FAIL %s_addr: addr=%h page=%h rd_req=%b, required addr=%h page=%h rd_req=1",
                 tag, addr_out, addr_out_page, rd_req, exp_addr, exp_page);
      end
      d = 8'($urandom);
      if (pop_with_ack && model_q.size() > 0) begin
        checks++;
        if (fifo_data !== model_q[0]) begin
          errors++;
          $display("FAIL %s_popack: fifo_data=%h, required %h", tag, fifo_data, model_q[0]);
        end
        head = model_q.pop_front();
        pop = 1'b1;
      end
      data_in = d;
      rd_ack = 1'b1;
      model_q.push_back(d);
      @(negedge CLK_200);
      pop = 1'b0;
      checks++;
      if (rd_req !== 1'b0 || fifo_level !== LW'(model_q.size())) begin
        errors++;
        $display("FAIL %s_push: rd_req=%b level=%0d, required rd_req=0 level=%0d",
                 tag, rd_req, fifo_level, model_q.size());
      end
      rd_ack = 1'b0;
      data_in = 8'h00;
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge CLK_200);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b err=%b, required 1/0/0", tag, done, busy, err);
    end
    @(negedge CLK_200);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b, required 0", tag, done);
    end
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] head;
    checks++;
    if (fifo_data !== model_q[0] || fifo_level !== LW'(model_q.size())) begin
      errors++;
      $display("FAIL %s_pop: data=%h level=%0d, required data=%h level=%0d",
               tag, fifo_data, fifo_level, model_q[0], model_q.size());
    end
    pop = 1'b1;
    @(negedge CLK_200);
    pop = 1'b0;
    head = model_q.pop_front();
  endtask

  task automatic drain_check(input string tag);
    while (model_q.size() > 0) pop_one(tag);
    // One extra pop against an empty FIFO must be ignored.
    pop = 1'b1;
    @(negedge CLK_200);
    pop = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL %s_empty: empty=%b level=%0d, required 1/0", tag, fifo_empty, fifo_level);
    end
  endtask

  task automatic run_burst(input logic [7:0] pg, input logic [13:0] b, input logic [8:0] l,
                           input int dmin, input int dmax, input bit rand_pop, input string tag);
    model_q.delete();
    pulse_start(pg, b, l, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: busy=%b, required 1", tag, busy);
    end
    for (int i = 0; i < int'(l); i++)
      serve_one($urandom_range(dmax, dmin), 14'(int'(b) + i), pg,
                rand_pop && ($urandom_range(1, 0) == 1), tag);
    check_done(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rd_ack = 1'b0;
    repeat (2) @(negedge CLK_200);
    reset_n = 1'b1;
    model_q.delete();
    @(negedge CLK_200);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; page_in = '0; base_in = '0; len_in = '0;
    data_in = '0; rd_ack = 1'b0; pop = 1'b0;
    repeat (3) @(negedge CLK_200);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rd_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b rd_req=%b, required 0/0/0/0",
               busy, done, err, rd_req);
    end
    checks++;
    if (addr_out !== '0 || addr_out_page !== '0) begin
      errors++;
      $display("FAIL reset_addr: addr=%h page=%h, required 0/0", addr_out, addr_out_page);
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_fifo: empty=%b level=%0d, required 1/0", fifo_empty, fifo_level);
    end
    reset_n = 1'b1;
    @(negedge CLK_200);
  endtask

  task automatic test_basic();
    run_burst(8'h03, 14'h0100, 9'd4, 2, 2, 1'b0, "basic");
    checks++;
    if (fifo_level !== LW'(4) || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_level: level=%0d empty=%b, required 4/0", fifo_level, fifo_empty);
    end
    drain_check("basic");
  endtask

  task automatic test_wrap();
    run_burst(8'($urandom), 14'h3FFE, 9'd4, 0, 1, 1'b0, "wrap");
    drain_check("wrap");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_burst(8'($urandom), 14'($urandom), 9'($urandom_range(12, 1)), 0, 3, 1'b1, "rand");
      drain_check("rand");
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    model_q.delete();
    pulse_start(8'h5A, 14'h0200, 9'd20, 1'b0);
    for (int i = 0; i < 16; i++) serve_one(1, 14'(14'h0200 + i), 8'h5A, 1'b0, "bp");
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK_200);
      if (rd_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || fifo_level !== LW'(16)) begin
      errors++;
      $display("FAIL bp_hold: req_seen=%b level=%0d, required 0/16", seen, fifo_level);
    end
    pop_one("bp");
    serve_one(1, 14'h0210, 8'h5A, 1'b0, "bp17");
    for (int i = 17; i < 20; i++) begin
      pop_one("bp");
      serve_one(0, 14'(14'h0200 + i), 8'h5A, 1'b0, "bp");
    end
    check_done("bp");
    drain_check("bp");
  endtask

  task automatic test_len_zero();
    bit seen;
    run_burst(8'h11, 14'h0040, 9'd3, 0, 1, 1'b0, "pre0");
    pulse_start(8'h77, 14'h1234, 9'd0, 1'b1);
    model_q.delete();
    checks++;
    if (done !== 1'b1 || fifo_level !== '0 || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: done=%b level=%0d empty=%b busy=%b, required 1/0/1/0",
               done, fifo_level, fifo_empty, busy);
    end
    seen = 1'b0;
    @(negedge CLK_200);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL len0_width: done=%b, required 0", done);
    end
    repeat (10) begin
      if (rd_req !== 1'b0) seen = 1'b1;
      @(negedge CLK_200);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL len0_noreq: rd_req seen=%b, required 0", seen);
    end
  endtask

  task automatic test_start_ignored();
    model_q.delete();
    pulse_start(8'h21, 14'h0800, 9'd8, 1'b0);
    serve_one(1, 14'h0800, 8'h21, 1'b0, "ign");
    serve_one(0, 14'h0801, 8'h21, 1'b0, "ign");
    pulse_start(8'h99, 14'h3000, 9'd3, 1'b0);
    checks++;
    if (busy !== 1'b1 || fifo_level !== LW'(2)) begin
      errors++;
      $display("FAIL ign_state: busy=%b level=%0d, required 1/2", busy, fifo_level);
    end
    for (int i = 2; i < 8; i++) serve_one($urandom_range(2, 0), 14'(14'h0800 + i), 8'h21, 1'b0, "ign");
    check_done("ign");
    drain_check("ign");
  endtask

  task automatic test_timeout();
    bit bad;
    int t;
    model_q.delete();
    pulse_start(8'h44, 14'h0010, 9'd3, 1'b0);
    serve_one(1, 14'h0010, 8'h44, 1'b0, "tmo");
    t = 0;
    while (rd_req !== 1'b1 && t < 100) begin
      @(negedge CLK_200);
      t++;
    end
    bad = (rd_req !== 1'b1);
`ifdef FETCH_TIMEOUT_EN
    repeat (TMO - 1) begin
      @(negedge CLK_200);
      if (err !== 1'b0 || rd_req !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL tmo_early: abort before %0d cycles, required none", TMO);
    end
    @(negedge CLK_200);
    checks++;
    if (err !== 1'b1 || rd_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: err=%b rd_req=%b busy=%b done=%b, required 1/0/0/0",
               err, rd_req, busy, done);
    end
    @(negedge CLK_200);
    checks++;
    if (err !== 1'b0 || fifo_level !== LW'(1) || fifo_data !== model_q[0]) begin
      errors++;
      $display("FAIL tmo_after: err=%b level=%0d data=%h, required 0/1/%h",
               err, fifo_level, fifo_data, model_q[0]);
    end
    drain_check("tmo");
`else
    repeat (TMO + 50) begin
      @(negedge CLK_200);
      if (err !== 1'b0 || rd_req !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || busy !== 1'b1) begin
      errors++;
      $display("FAIL notmo_hold: stall broken=%b busy=%b, required 0/1", bad, busy);
    end
    do_reset();
`endif
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    int t;
    model_q.delete();
    pulse_start(8'h66, 14'h0400, 9'd8, 1'b0);
    serve_one(0, 14'h0400, 8'h66, 1'b0, "rst");
    serve_one(0, 14'h0401, 8'h66, 1'b0, "rst");
    t = 0;
    while (rd_req !== 1'b1 && t < 100) begin
      @(negedge CLK_200);
      t++;
    end
    data_in = 8'hC3;
    rd_ack = 1'b1;
    @(negedge CLK_200);
    reset_n = 1'b0;
    @(negedge CLK_200);
    rd_ack = 1'b0;
    model_q.delete();
    checks++;
    if (rd_req !== 1'b0 || fifo_empty !== 1'b1 || fifo_level !== '0 ||
        done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rd_req=%b empty=%b level=%0d done=%b err=%b busy=%b, required 0/1/0/0/0/0",
               rd_req, fifo_empty, fifo_level, done, err, busy);
    end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK_200);
      if (done !== 1'b0 || err !== 1'b0 || rd_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_quiet: activity after reset=%b, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
    test_timeout();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
